spi_flash_loader: RTL and testbench

Command sequencer that sits directly upstream of the `spi` byte engine and turns one load request into a complete SPI-flash READ (0x03) transaction. It drives the engine's `start`/`data_in` handshake and owns the flash chip-select. It consumes `data_out`/`new_data` and writes each received byte into VIC-side memory (character ROM, palette, screen RAM) through a simple write port. Used at boot and on host request to fill on-chip RAM from external flash.

---
 rtl/lobovic_spi_pkg.sv | 44 ++++
 rtl/spi_flash_loader.sv | 178 +++++++++++++++++
 tb/tb_spi_flash_loader.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lobovic_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lobovic_spi_pkg
//  Purpose  : Shared types and constants for the SPI-flash loader: sequencer
//             state enum, flash READ opcode, dummy byte, header length and a
//             helper that selects one header byte.
//  Revision : 1.0 - initial release
// ============================================================================
package lobovic_spi_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_FIN   = 3'd5
    } ldr_state_e;

    localparam logic [7:0] C_READ_CMD   = 8'h03;
    localparam logic [7:0] C_DUMMY_BYTE = 8'h00;

    // Opcode plus three address bytes precede the data phase
    localparam int C_HDR_LEN = 4;

    // Header byte idx: 0 = opcode, 1..3 = address MSB first
    function automatic logic [7:0] hdr_byte(
        input logic [7:0]  cmd,
        input logic [23:0] addr,
        input logic [1:0]  idx
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = cmd;
            2'd1:    b = addr[23:16];
            2'd2:    b = addr[15:8];
            default: b = addr[7:0];
        endcase
        return b;
    endfunction

endpackage : lobovic_spi_pkg
`default_nettype wire

// File: rtl/spi_flash_loader.sv
`default_nettype none
// ============================================================================
//  Module   : spi_flash_loader
//  Purpose  : Turns one load request into a SPI-flash READ transaction on an
//             external byte engine and streams the returned data bytes into
//             a destination memory through a simple write port.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_flash_loader
    import lobovic_spi_pkg::*;
#(
    parameter int         CS_SETUP = 4,
    parameter int         CS_HOLD  = 4,
    parameter int         LEN_W    = 16,
    parameter int         DST_AW   = 14,
    parameter logic [7:0] READ_CMD = C_READ_CMD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    input  logic [23:0]       src_addr_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [DST_AW-1:0] dst_base_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              cs_n_o,
    output logic              spi_start_o,
    output logic [7:0]        spi_data_in_o,
    input  logic [7:0]        spi_data_out_i,
    input  logic              spi_busy_i,
    input  logic              spi_new_data_i,
    output logic              wr_en_o,
    output logic [DST_AW-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);

    // Byte counter carries 4+len without overflow even for len = 2^LEN_W-1
    localparam int CNT_W   = LEN_W + 3;
    localparam int TMR_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

    ldr_state_e        state_q, state_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [23:0]       src_q, src_d;
    logic [DST_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [7:0]        spi_data_in_q, spi_data_in_d;
    logic              cs_n_q, cs_n_d;
    logic              done_q, done_d;
    logic              wr_en_q, wr_en_d;
    logic [DST_AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic w_accept;
    logic w_byte_done;
    logic w_data_byte;
    logic w_last;
    logic w_setup_done;
    logic w_hold_done;

    assign w_accept     = (state_q == ST_IDLE) && req_i && (len_i != '0);
    assign w_byte_done  = (state_q == ST_WAIT) && spi_new_data_i;
    assign w_data_byte  = (cnt_q >= CNT_W'(C_HDR_LEN));
    assign w_last       = ((cnt_q + CNT_W'(1)) == total_q);
    assign w_setup_done = (tmr_q == TMR_W'(CS_SETUP - 1));
    assign w_hold_done  = (tmr_q == TMR_W'(CS_HOLD - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: request accept, CS setup/hold timing, byte issue/complete
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_i) state_d = (len_i == '0) ? ST_FIN : ST_SETUP;
            ST_SETUP: if (w_setup_done) state_d = ST_ISSUE;
            ST_ISSUE: if (!spi_busy_i) state_d = ST_WAIT;
            ST_WAIT:  if (spi_new_data_i) state_d = w_last ? ST_HOLD : ST_ISSUE;
            ST_HOLD:  if (w_hold_done) state_d = ST_FIN;
            ST_FIN:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs; start fires only once the engine is free
    always_comb begin
        busy_o      = (state_q != ST_IDLE);
        spi_start_o = (state_q == ST_ISSUE) && !spi_busy_i;
    end

    // Datapath next values: capture, byte counting, TX byte, write port
    always_comb begin
        tmr_d         = '0;
        cnt_d         = cnt_q;
        total_d       = total_q;
        src_d         = src_q;
        wr_ptr_d      = wr_ptr_q;
        spi_data_in_d = spi_data_in_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;

        if ((state_q == ST_SETUP) || (state_q == ST_HOLD)) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        if (w_accept) begin
            cnt_d    = '0;
            total_d  = CNT_W'(len_i) + CNT_W'(C_HDR_LEN);
            src_d    = src_addr_i;
            wr_ptr_d = dst_base_i;
        end else if (w_byte_done) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (w_data_byte) begin
                wr_en_d   = 1'b1;
                wr_addr_d = wr_ptr_q;
                wr_data_d = spi_data_out_i;
                wr_ptr_d  = wr_ptr_q + DST_AW'(1);
            end
        end

        // Load the next TX byte on entry to ISSUE so it is ready with start
        if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) begin
            spi_data_in_d = (cnt_d < CNT_W'(C_HDR_LEN))
                          ? hdr_byte(READ_CMD, src_q, cnt_d[1:0])
                          : C_DUMMY_BYTE;
        end

        // Chip-select low through setup, transfer and hold
        cs_n_d = !(state_d inside {ST_SETUP, ST_ISSUE, ST_WAIT, ST_HOLD});
        done_d = (state_q == ST_FIN);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q         <= '0;
            cnt_q         <= '0;
            total_q       <= '0;
            src_q         <= '0;
            wr_ptr_q      <= '0;
            spi_data_in_q <= '0;
            cs_n_q        <= 1'b1;
            done_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            tmr_q         <= tmr_d;
            cnt_q         <= cnt_d;
            total_q       <= total_d;
            src_q         <= src_d;
            wr_ptr_q      <= wr_ptr_d;
            spi_data_in_q <= spi_data_in_d;
            cs_n_q        <= cs_n_d;
            done_q        <= done_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    assign done_o        = done_q;
    assign cs_n_o        = cs_n_q;
    assign spi_data_in_o = spi_data_in_q;
    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;

endmodule : spi_flash_loader
`default_nettype wire

// File: tb/tb_spi_flash_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_flash_loader
//  Purpose  : Self-checking bench for spi_flash_loader with a byte-engine and
//             flash responder model and a transaction-level reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [23:0] src_addr;
    logic [15:0] len;
    logic [13:0] dst_base;
    logic        busy, done, cs_n, spi_start;
    logic [7:0]  spi_data_in;
    logic [7:0]  spi_data_out;
    logic        spi_busy;
    logic        spi_new_data;
    logic        wr_en;
    logic [13:0] wr_addr;
    logic [7:0]  wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    spi_flash_loader dut (
        .clk            (clk),
        .rst            (rst),
        .req_i          (req),
        .src_addr_i     (src_addr),
        .len_i          (len),
        .dst_base_i     (dst_base),
        .busy_o         (busy),
        .done_o         (done),
        .cs_n_o         (cs_n),
        .spi_start_o    (spi_start),
        .spi_data_in_o  (spi_data_in),
        .spi_data_out_i (spi_data_out),
        .spi_busy_i     (spi_busy),
        .spi_new_data_i (spi_new_data),
        .wr_en_o        (wr_en),
        .wr_addr_o      (wr_addr),
        .wr_data_o      (wr_data)
    );

    always #5 clk = ~clk;

    // ---------------- byte engine + flash responder model ----------------
    int         eng_cnt   = 0;
    int         tail_cnt  = 0;
    int         frame_idx = 0;
    int         proto_err = 0;
    logic [7:0] cur_tx;
    logic [7:0] miso_q[$];
    logic [7:0] mosi_q[$];

    assign spi_busy = (eng_cnt != 0) || (tail_cnt != 0);

    // Engine: variable byte time, busy may linger after new_data
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_cnt      <= 0;
            tail_cnt     <= 0;
            frame_idx    <= 0;
            cur_tx       <= 8'h00;
            spi_new_data <= 1'b0;
            spi_data_out <= 8'h00;
        end else begin
            spi_new_data <= 1'b0;
            if (tail_cnt != 0) tail_cnt <= tail_cnt - 1;
            if (spi_start) begin
                if (spi_busy) proto_err <= proto_err + 1;
                cur_tx  <= spi_data_in;
                eng_cnt <= $urandom_range(1, 4);
            end else if (eng_cnt == 1) begin
                if (spi_data_in !== cur_tx) proto_err <= proto_err + 1;
                mosi_q.push_back(cur_tx);
                spi_new_data <= 1'b1;
                spi_data_out <= (frame_idx >= 4 && miso_q.size() != 0) ?
                                miso_q.pop_front() : 8'($urandom);
                tail_cnt  <= $urandom_range(0, 2);
                eng_cnt   <= 0;
                frame_idx <= frame_idx + 1;
            end else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
            end
            if (cs_n) frame_idx <= 0;
        end
    end

    // ---------------- event monitor ----------------
    int          cyc = 0;
    logic        cs_prev = 1'b1;
    int          start_c[$], nd_c[$], wr_c[$], done_c[$], fall_c[$], rise_c[$], busy_c[$];
    logic [13:0] wr_a[$];
    logic [7:0]  wr_d[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        cs_prev <= cs_n;
        if (spi_start)    start_c.push_back(cyc);
        if (spi_new_data) nd_c.push_back(cyc);
        if (done)         done_c.push_back(cyc);
        if (busy)         busy_c.push_back(cyc);
        if (!cs_n && cs_prev) fall_c.push_back(cyc);
        if (cs_n && !cs_prev) rise_c.push_back(cyc);
        if (wr_en) begin
            wr_c.push_back(cyc);
            wr_a.push_back(wr_addr);
            wr_d.push_back(wr_data);
        end
    end

    function automatic int q_first(input int q[$]);
        return (q.size() != 0) ? q[0] : -1000;
    endfunction

    function automatic int q_last(input int q[$]);
        return (q.size() != 0) ? q[q.size()-1] : -1000;
    endfunction

    task automatic clear_logs();
        start_c.delete(); nd_c.delete(); wr_c.delete(); done_c.delete();
        fall_c.delete(); rise_c.delete(); busy_c.delete();
        wr_a.delete(); wr_d.delete(); mosi_q.delete(); miso_q.delete();
    endtask

    // Issue one request and wait (bounded) for done; optional stray req
    task automatic run_load(input logic [23:0] s, input logic [15:0] l,
                            input logic [13:0] d, input int rereq_at,
                            output int t, output bit to);
        int budget;
        budget = 20 * (int'(l) + 4) + 100;
        @(negedge clk); #1;
        src_addr = s; len = l; dst_base = d; req = 1'b1;
        t = cyc;
        @(negedge clk); #1;
        req = 1'b0;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done_c.size() != 0) begin
                to = 1'b0;
                break;
            end
            req = (i == rereq_at);
            if (req) begin
                src_addr = ~s; len = l + 16'd5; dst_base = ~d;
            end
            @(negedge clk); #1;
        end
        req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_basic();
        logic [7:0] exp_m[$];
        int t;
        bit to;
        clear_logs();
        miso_q.push_back(8'hAA); miso_q.push_back(8'hBB); miso_q.push_back(8'hCC);
        exp_m = {8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00};
        run_load(24'h012345, 16'd3, 14'h0100, -1, t, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL basic_timeout: done not seen"); end
        n_tests++; if (mosi_q.size() != 7) begin n_fail++; $display("FAIL basic_mosi_count: got %0d want 7", mosi_q.size()); end
        for (int i = 0; i < 7; i++) begin
            n_tests++;
            if (i >= mosi_q.size() || mosi_q[i] !== exp_m[i]) begin
                n_fail++; $display("FAIL basic_mosi[%0d]: got %h want %h", i, (i < mosi_q.size()) ? mosi_q[i] : 8'hxx, exp_m[i]);
            end
        end
        n_tests++; if (wr_c.size() != 3) begin n_fail++; $display("FAIL basic_wr_count: got %0d want 3", wr_c.size()); end
        for (int i = 0; i < 3 && i < wr_c.size(); i++) begin
            n_tests++;
            if (wr_a[i] !== 14'(16'h0100 + i) || wr_d[i] !== 8'(8'hAA + 8'(i * 17))) begin
                n_fail++; $display("FAIL basic_wr[%0d]: got (%h,%h) want (%h,%h)", i, wr_a[i], wr_d[i], 14'(16'h0100 + i), 8'(8'hAA + 8'(i * 17)));
            end
        end
        n_tests++; if (done_c.size() != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d want 1", done_c.size()); end
        n_tests++; if (q_first(busy_c) != t + 1) begin n_fail++; $display("FAIL basic_busy_rise: got %0d want %0d", q_first(busy_c), t + 1); end
        n_tests++; if (q_first(fall_c) != t + 1) begin n_fail++; $display("FAIL basic_cs_fall: got %0d want %0d", q_first(fall_c), t + 1); end
        n_tests++; if (q_first(start_c) != t + 5) begin n_fail++; $display("FAIL basic_first_start: got %0d want %0d", q_first(start_c), t + 5); end
        n_tests++; if (q_first(done_c) != q_first(rise_c) + 1) begin n_fail++; $display("FAIL basic_done_after_cs: got %0d want %0d", q_first(done_c), q_first(rise_c) + 1); end
        n_tests++; if (q_last(busy_c) != q_first(done_c) - 1) begin n_fail++; $display("FAIL basic_busy_fall: last busy %0d want %0d", q_last(busy_c), q_first(done_c) - 1); end
        n_tests++; if (q_first(rise_c) - q_last(wr_c) < 4) begin n_fail++; $display("FAIL basic_wr_hold: got %0d want >=4", q_first(rise_c) - q_last(wr_c)); end
    endtask

    task automatic test_reset();
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        n_tests++; if (cs_n !== 1'b1)      begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (done !== 1'b0)      begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_tests++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_spi_start: got %b want 0", spi_start); end
        n_tests++; if (wr_en !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
        n_tests++; if (spi_data_in !== 8'h00) begin n_fail++; $display("FAIL reset_spi_data_in: got %h want 00", spi_data_in); end
        n_tests++; if (wr_addr !== 14'h0)  begin n_fail++; $display("FAIL reset_wr_addr: got %h want 0000", wr_addr); end
        n_tests++; if (wr_data !== 8'h00)  begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_len();
        int t;
        bit to;
        clear_logs();
        run_load(24'($urandom), 16'd0, 14'($urandom), -1, t, to);
        n_tests++; if (to) begin n_fail++; $display("FAIL zero_timeout: done not seen"); end
        n_tests++; if (done_c.size() != 1 || q_first(done_c) != t + 2) begin n_fail++; $display("FAIL zero_done: got %0d (n=%0d) want %0d", q_first(done_c), done_c.size(), t + 2); end
        n_tests++; if (fall_c.size() != 0) begin n_fail++; $display("FAIL zero_cs_n: got %0d falls want 0", fall_c.size()); end
        n_tests++; if (start_c.size() != 0) begin n_fail++; $display("FAIL zero_start: got %0d starts want 0", start_c.size()); end
        n_tests++; if (busy_c.size() != 1 || q_first(busy_c) != t + 1) begin n_fail++; $display("FAIL zero_busy: got %0d cycles first %0d want 1 at %0d", busy_c.size(), q_first(busy_c), t + 1); end
        n_tests++; if (wr_c.size() != 0) begin n_fail++; $display("FAIL zero_writes: got %0d want 0", wr_c.size()); end
    endtask

    task automatic test_wrap();
        logic [7:0]  dat[$];
        logic [13:0] exp_a[4];
        int t;
        bit to;
        exp_a = '{14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001};
        clear_logs();
        for (int i = 0; i < 4; i++) dat.push_back(8'($urandom));
        miso_q = dat;
        run_load(24'($urandom), 16'd4, 14'h3FFE, -1, t, to);
        n_tests++; if (to || wr_c.size() != 4) begin n_fail++; $display("FAIL wrap_count: got %0d writes (timeout=%0d) want 4", wr_c.size(), to); end
        for (int i = 0; i < 4 && i < wr_c.size(); i++) begin
            n_tests++;
            if (wr_a[i] !== exp_a[i] || wr_d[i] !== dat[i]) begin
                n_fail++; $display("FAIL wrap_wr[%0d]: got (%h,%h) want (%h,%h)", i, wr_a[i], wr_d[i], exp_a[i], dat[i]);
            end
        end
    endtask

    task automatic test_timing_ignore();
        logic [7:0]  dat[$];
        logic [7:0]  exp_m[$];
        logic [23:0] s;
        logic [13:0] d;
        int l, t;
        bit to;
        clear_logs();
        s = 24'($urandom); d = 14'($urandom); l = $urandom_range(2, 6);
        for (int i = 0; i < l; i++) dat.push_back(8'($urandom));
        miso_q = dat;
        exp_m = {8'h03, s[23:16], s[15:8], s[7:0]};
        for (int i = 0; i < l; i++) exp_m.push_back(8'h00);
        run_load(s, 16'(l), d, 6, t, to);
        repeat (20) @(negedge clk);
        #1;
        n_tests++; if (to) begin n_fail++; $display("FAIL timing_timeout: done not seen"); end
        n_tests++; if (q_first(start_c) - q_first(fall_c) != 4) begin n_fail++; $display("FAIL timing_setup: got %0d want 4", q_first(start_c) - q_first(fall_c)); end
        n_tests++; if (q_first(rise_c) - q_last(nd_c) < 4) begin n_fail++; $display("FAIL timing_hold: got %0d want >=4", q_first(rise_c) - q_last(nd_c)); end
        n_tests++; if (fall_c.size() != 1 || done_c.size() != 1) begin n_fail++; $display("FAIL ignore_req: got %0d cs falls, %0d dones want 1,1", fall_c.size(), done_c.size()); end
        n_tests++; if (mosi_q != exp_m) begin n_fail++; $display("FAIL ignore_mosi: got %0d bytes want %0d (first-req contents)", mosi_q.size(), exp_m.size()); end
        n_tests++; if (wr_c.size() != l) begin n_fail++; $display("FAIL ignore_wr_count: got %0d want %0d", wr_c.size(), l); end
        for (int i = 0; i < l && i < wr_c.size(); i++) begin
            n_tests++;
            if (wr_a[i] !== 14'((int'(d) + i) % 16384) || wr_d[i] !== dat[i]) begin
                n_fail++; $display("FAIL ignore_wr[%0d]: got (%h,%h) want (%h,%h)", i, wr_a[i], wr_d[i], 14'((int'(d) + i) % 16384), dat[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            logic [7:0]  dat[$];
            logic [7:0]  exp_m[$];
            logic [23:0] s;
            logic [13:0] d;
            int l, t, bad;
            bit to;
            clear_logs();
            s = 24'($urandom); d = 14'($urandom); l = $urandom_range(1, 12);
            for (int i = 0; i < l; i++) dat.push_back(8'($urandom));
            miso_q = dat;
            exp_m = {8'h03, s[23:16], s[15:8], s[7:0]};
            for (int i = 0; i < l; i++) exp_m.push_back(8'h00);
            run_load(s, 16'(l), d, -1, t, to);
            n_tests++; if (to || done_c.size() != 1) begin n_fail++; $display("FAIL rand%0d_done: got %0d dones (timeout=%0d) want 1", r, done_c.size(), to); end
            n_tests++; if (mosi_q != exp_m) begin n_fail++; $display("FAIL rand%0d_mosi: got %0d bytes want %0d, contents differ", r, mosi_q.size(), exp_m.size()); end
            bad = (wr_c.size() != l) ? 1 : 0;
            for (int i = 0; i < l && i < wr_c.size(); i++)
                if (wr_a[i] !== 14'((int'(d) + i) % 16384) || wr_d[i] !== dat[i]) bad++;
            n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rand%0d_writes: %0d bad of %0d writes want %0d exact", r, bad, wr_c.size(), l); end
        end
        n_tests++; if (proto_err != 0) begin n_fail++; $display("FAIL engine_protocol: got %0d violations want 0", proto_err); end
    endtask

    task automatic test_reset_midop();
        logic [7:0] dat[$];
        int t;
        bit to, seen;
        clear_logs();
        for (int i = 0; i < 8; i++) dat.push_back(8'($urandom));
        miso_q = dat;
        @(negedge clk); #1;
        src_addr = 24'($urandom); len = 16'd8; dst_base = 14'($urandom); req = 1'b1;
        @(negedge clk); #1;
        req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (wr_c.size() >= 2) begin seen = 1'b1; break; end
            @(negedge clk); #1;
        end
        n_tests++; if (!seen) begin n_fail++; $display("FAIL midop_progress: got %0d writes want 2", wr_c.size()); end
        #1;
        rst = 1'b1;
        #1;
        n_tests++; if (cs_n !== 1'b1 || spi_start !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0)
            begin n_fail++; $display("FAIL midop_async: got cs_n=%b start=%b wr_en=%b busy=%b want 1,0,0,0", cs_n, spi_start, wr_en, busy); end
        @(negedge clk); #2;
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        n_tests++; if (done_c.size() != 0) begin n_fail++; $display("FAIL midop_no_done: got %0d dones want 0", done_c.size()); end
        clear_logs();
        dat.delete();
        for (int i = 0; i < 3; i++) dat.push_back(8'($urandom));
        miso_q = dat;
        run_load(24'h00ABCD, 16'd3, 14'h0200, -1, t, to);
        n_tests++; if (to || done_c.size() != 1 || wr_c.size() != 3) begin n_fail++; $display("FAIL midop_reload: got %0d dones %0d writes want 1,3", done_c.size(), wr_c.size()); end
        for (int i = 0; i < 3 && i < wr_c.size(); i++) begin
            n_tests++;
            if (wr_a[i] !== 14'(16'h0200 + i) || wr_d[i] !== dat[i]) begin
                n_fail++; $display("FAIL midop_wr[%0d]: got (%h,%h) want (%h,%h)", i, wr_a[i], wr_d[i], 14'(16'h0200 + i), dat[i]);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; src_addr = '0; len = '0; dst_base = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        test_basic();
        test_reset();
        test_zero_len();
        test_wrap();
        test_timing_ignore();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_spi_flash_loader
`default_nettype wire
